// File: rtl/steer2_sync.sv
// Purpose : clocked 1-to-2 demux for 4-phase bundled-data channels; d_i[SEL_BIT] picks channel 0 or 1.
// Latency : SYNC_STAGES+1 cycles from each async handshake edge to the registered response edge.
// Backpr. : a_i is withheld until the selected consumer acks; a new token is taken only from IDLE.
//
// Ports:
//   clk, rst (async, active-low)
//   r_i / a_i / d_i     : upstream channel (r_i async in, a_i registered out, d_i bundled with r_i)
//   r0_o / a0_o / d0_o  : channel 0 (r0_o registered out, a0_o async in)
//   r1_o / a1_o / d1_o  : channel 1 (r1_o registered out, a1_o async in)
//   busy                : FSM not in IDLE
//   err                 : sticky protocol error (stray ack on the unselected channel, or any ack in IDLE)
//
// Optional feature macro: STEER_CAPTURE_EN
//   defined   -> d_i captured on IDLE->FWD, d0_o/d1_o driven from that register
//   undefined -> d0_o/d1_o follow d_i combinationally
module steer2_sync #(
  parameter int N           = 1,
  parameter int SEL_BIT     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  output logic         r0_o,
  input  logic         a0_o,
  output logic [N-1:0] d0_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, FWD, ACKD, RTZ} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] rs_sync_q,  rs_sync_d;
  logic [SYNC_STAGES-1:0] as0_sync_q, as0_sync_d;
  logic [SYNC_STAGES-1:0] as1_sync_q, as1_sync_d;

  logic sel_q,  sel_d;
  logic a_i_q,  a_i_d;
  logic r0_q,   r0_d;
  logic r1_q,   r1_d;
  logic busy_q, busy_d;
  logic err_q,  err_d;

  logic rs, as0, as1;
  logic as_sel, as_other;

  // Shift registers: the newest sample enters at bit 0, the FSM reads the oldest bit.
  always_comb begin
    rs_sync_d  = {rs_sync_q[SYNC_STAGES-2:0],  r_i};
    as0_sync_d = {as0_sync_q[SYNC_STAGES-2:0], a0_o};
    as1_sync_d = {as1_sync_q[SYNC_STAGES-2:0], a1_o};
  end

  assign rs  = rs_sync_q[SYNC_STAGES-1];
  assign as0 = as0_sync_q[SYNC_STAGES-1];
  assign as1 = as1_sync_q[SYNC_STAGES-1];

  assign as_sel   = sel_q ? as1 : as0;
  assign as_other = sel_q ? as0 : as1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (rs) begin
        sel_d   = d_i[SEL_BIT];
        state_d = FWD;
      end
      FWD:  if (as_sel) state_d = ACKD;
      ACKD: if (!rs)    state_d = RTZ;
      RTZ:  if (!as_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge at which the FSM enters the state that drives them.
    r0_d   = ((state_d == FWD) || (state_d == ACKD)) && !sel_d;
    r1_d   = ((state_d == FWD) || (state_d == ACKD)) &&  sel_d;
    a_i_d  = (state_d == ACKD) || (state_d == RTZ);
    busy_d = (state_d != IDLE);

    // sel_q is only meaningful outside IDLE; in IDLE any ack is stray.
    err_d  = err_q | ((state_q == IDLE) ? (as0 | as1) : as_other);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rs_sync_q  <= '0;
      as0_sync_q <= '0;
      as1_sync_q <= '0;
      sel_q      <= 1'b0;
      a_i_q      <= 1'b0;
      r0_q       <= 1'b0;
      r1_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_sync_q  <= rs_sync_d;
      as0_sync_q <= as0_sync_d;
      as1_sync_q <= as1_sync_d;
      sel_q      <= sel_d;
      a_i_q      <= a_i_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

`ifdef STEER_CAPTURE_EN
  logic [N-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if ((state_q == IDLE) && rs) data_d = d_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign d0_o = data_q;
  assign d1_o = data_q;
`else
  assign d0_o = d_i;
  assign d1_o = d_i;
`endif

  assign a_i  = a_i_q;
  assign r0_o = r0_q;
  assign r1_o = r1_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_steer2_sync.sv
// Directed bench for steer2_sync with N=8, SEL_BIT=7, SYNC_STAGES=2.
// Each handshake response is timed to the cycle; expected values are hand-derived.
module tb_steer2_sync;

  localparam int N   = 8;
  localparam int LAT = 3; // SYNC_STAGES+1

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         r_i = 1'b0;
  logic         a_i;
  logic [N-1:0] d_i = '0;
  logic         r0_o;
  logic         a0_o = 1'b0;
  logic [N-1:0] d0_o;
  logic         r1_o;
  logic         a1_o = 1'b0;
  logic [N-1:0] d1_o;
  logic         busy;
  logic         err;

  int nvec = 0;
  int nerr = 0;

  int r0_cycles = 0;
  int r1_cycles = 0;
  int overlap   = 0;

  always #5 clk = ~clk;

  steer2_sync #(.N(N), .SEL_BIT(7), .SYNC_STAGES(2)) dut (
    .clk (clk),  .rst (rst),
    .r_i (r_i),  .a_i (a_i),  .d_i (d_i),
    .r0_o(r0_o), .a0_o(a0_o), .d0_o(d0_o),
    .r1_o(r1_o), .a1_o(a1_o), .d1_o(d1_o),
    .busy(busy), .err (err)
  );

  // Request activity monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (r0_o) r0_cycles <= r0_cycles + 1;
    if (r1_o) r1_cycles <= r1_cycles + 1;
    if (r0_o && r1_o) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_sig(input int idx);
    case (idx)
      0: return a_i;
      1: return r0_o;
      2: return r1_o;
      3: return busy;
      default: return err;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts cycles until signal idx reaches val and requires exactly LAT.
  task automatic measure(input string tag, input int idx, input logic val);
    int n = 0;
    while (get_sig(idx) !== val && n < 20) begin
      tick(1);
      n++;
    end
    chk(tag, n, LAT);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    r_i = 1'b0; a0_o = 1'b0; a1_o = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  // Full 4-phase token with every response timed.
  task automatic do_token(input logic [7:0] d);
    int   c     = d[7] ? 2 : 1;
    int   other = 0;
    other = d[7] ? r0_cycles : r1_cycles;
    d_i = d;
    r_i = 1'b1;
    measure("req_rise", c, 1'b1);
    chk("d0_data", d0_o, d);
    chk("d1_data", d1_o, d);
    chk("busy_hi", busy, 1'b1);
    if (d[7]) a1_o = 1'b1; else a0_o = 1'b1;
    measure("ack_in_rise", 0, 1'b1);
    r_i = 1'b0;
    measure("req_fall", c, 1'b0);
    if (d[7]) a1_o = 1'b0; else a0_o = 1'b0;
    measure("ack_in_fall", 0, 1'b0);
    chk("busy_lo", busy, 1'b0);
    chk("unsel_quiet", d[7] ? r0_cycles : r1_cycles, other);
  endtask

  initial begin
    logic [7:0] tok;

    // Reset held while the handshake inputs are asserted.
    d_i = 8'h35; r_i = 1'b1; a0_o = 1'b1;
    tick(4);
    chk("rst_a_i",  a_i,  1'b0);
    chk("rst_r0",   r0_o, 1'b0);
    chk("rst_r1",   r1_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err",  err,  1'b0);
    rst = 1'b1;
    measure("post_rst_req", 1, 1'b1);
    chk("post_rst_err", err, 1'b1);
    chk("post_rst_r1", r1_o, 1'b0);
    r_i = 1'b0;
    tick(LAT + 1);
    a0_o = 1'b0;
    wait_idle("post_rst_idle");
    chk("err_sticky", err, 1'b1);
    apply_reset();
    chk("err_cleared", err, 1'b0);

    // Single tokens to each channel.
    do_token(8'h35);
    do_token(8'hA0);
    chk("err_after_single", err, 1'b0);

    // Alternating stream of 16 tokens.
    for (int i = 0; i < 16; i++) begin
      tok = {i[0], 3'b010, i[3:0]};
      do_token(tok);
    end
    chk("stream_overlap", overlap, 0);
    chk("stream_err", err, 1'b0);

    // Stray ack on channel 1 during a channel-0 token.
    d_i = 8'h35;
    r_i = 1'b1;
    measure("perr_req", 1, 1'b1);
    chk("perr_err_pre", err, 1'b0);
    a1_o = 1'b1;
    tick(4);
    a1_o = 1'b0;
    chk("perr_err_set", err, 1'b1);
    chk("perr_r1", r1_o, 1'b0);
    a0_o = 1'b1;
    measure("perr_ack", 0, 1'b1);
    r_i = 1'b0;
    measure("perr_req_fall", 1, 1'b0);
    a0_o = 1'b0;
    measure("perr_ack_fall", 0, 1'b0);
    chk("perr_err_hold", err, 1'b1);
    apply_reset();

    // Asynchronous reset in the middle of a channel-1 token.
    d_i = 8'hA0;
    r_i = 1'b1;
    measure("mid_req", 2, 1'b1);
    a1_o = 1'b1;
    measure("mid_ack", 0, 1'b1);
    #2;
    rst = 1'b0; r_i = 1'b0; a1_o = 1'b0;
    #1;
    chk("mid_a_i",  a_i,  1'b0);
    chk("mid_r1",   r1_o, 1'b0);
    chk("mid_busy", busy, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(6);
    chk("mid_busy_after", busy, 1'b0);
    chk("mid_err_after",  err,  1'b0);

`ifdef STEER_CAPTURE_EN
    // Captured data must survive d_i changing after the capture edge.
    d_i = 8'h12;
    r_i = 1'b1;
    measure("cap_req", 1, 1'b1);
    tick(2);
    d_i = 8'hFF;
    tick(1);
    chk("cap_d0_hold", d0_o, 8'h12);
    chk("cap_d1_hold", d1_o, 8'h12);
    a0_o = 1'b1;
    measure("cap_ack", 0, 1'b1);
    r_i = 1'b0;
    measure("cap_req_fall", 1, 1'b0);
    a0_o = 1'b0;
    measure("cap_ack_fall", 0, 1'b0);
    tick(2);
    chk("cap_d0_idle", d0_o, 8'h12);
    do_token(8'h9C);
`else
    // Without capture the outputs follow d_i directly.
    d_i = 8'h5A;
    #1;
    chk("pass_d0", d0_o, 8'h5A);
    chk("pass_d1", d1_o, 8'h5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
